// File: rtl/fetch_ctrl.sv
// Fetch-stage hazard controller: steers PC and IF/ID/ID/EX enables for stalls, branch flushes and imem waits.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_hz,
  input  logic        br_taken,
  input  logic        imem_valid,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic        imem_timeout
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_FLUSH = 2'b10,
    S_WAIT  = 2'b11
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q;

  // NOTE: every output and next-state variable gets a default before the
  // case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    pc_en      = 1'b0;
    pc_sel     = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;

    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = S_RUN;
    end else if (br_taken) begin
      pc_en      = 1'b1;
      pc_sel     = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = S_FLUSH;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (load_use_hz) begin
            idex_flush = 1'b1;
            state_d    = S_STALL;
          end else if (!imem_valid) begin
            idex_flush = 1'b1;
            state_d    = S_WAIT;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
        // The stalled load has moved on, so a repeated hazard flag is stale.
        S_STALL: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          state_d = S_RUN;
        end
        S_FLUSH: begin
          if (load_use_hz) begin
            idex_flush = 1'b1;
            state_d    = S_STALL;
          end else begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            state_d    = S_RUN;
          end
        end
        S_WAIT: begin
          if (!imem_valid) begin
            idex_flush = 1'b1;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            state_d = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Counter holds the number of WAIT cycles so far, including the current one.
  always_comb begin
    wait_d = 8'd0;
    if (state_d == S_WAIT) begin
      wait_d = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (wait_q == WAIT_LAST && !imem_valid) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign state        = state_q;
  assign imem_timeout = timeout_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_en && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (br_taken && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
